// File: rtl/cpu_bus_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the bus arbiter.
// master: arbiter view; slave: requesters and memory (environment) view.
interface cpu_bus_arbiter_if;
   logic        cpui_request;
   logic [31:0] cpui_addr;
   logic [31:0] cpui_rdata;
   logic        cpui_ack;
   logic        cpud_request;
   logic        cpud_write;
   logic [31:0] cpud_addr;
   logic [31:0] cpud_wdata;
   logic [3:0]  cpud_wmask;
   logic [31:0] cpud_rdata;
   logic        cpud_ack;
   logic        mem_request;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        bus_error;

   modport master (
      input  cpui_request, cpui_addr,
      output cpui_rdata, cpui_ack,
      input  cpud_request, cpud_write, cpud_addr,
      input  cpud_wdata, cpud_wmask,
      output cpud_rdata, cpud_ack,
      output mem_request, mem_write, mem_addr,
      output mem_wdata, mem_wmask,
      input  mem_rdata, mem_ack,
      output bus_error
   );

   modport slave (
      output cpui_request, cpui_addr,
      input  cpui_rdata, cpui_ack,
      output cpud_request, cpud_write, cpud_addr,
      output cpud_wdata, cpud_wmask,
      input  cpud_rdata, cpud_ack,
      input  mem_request, mem_write, mem_addr,
      input  mem_wdata, mem_wmask,
      output mem_rdata, mem_ack,
      input  bus_error
   );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store.
// One transaction outstanding at a time; optional watchdog ends hung ones.
module cpu_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic               clock,
   input  logic               reset,
   cpu_bus_arbiter_if.master  bus
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY_I = 2'd1,
      S_BUSY_D = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_last_d;
   logic [31:0] r_wdog;

   logic        r_pi_valid;
   logic [31:0] r_pi_addr;
   logic        r_pd_valid;
   logic        r_pd_write;
   logic [31:0] r_pd_addr;
   logic [31:0] r_pd_wdata;
   logic [3:0]  r_pd_wmask;

   logic        w_busy;
   logic        w_expire;
   logic        w_end;
   logic        w_can;
   logic        w_err_i;
   logic        w_err_d;
   logic        w_live_i;
   logic        w_live_d;
   logic        w_cand_i;
   logic        w_cand_d;
   logic        w_gnt_i;
   logic        w_gnt_d;
   logic        w_d_write;

   // Arbitration, grant muxing, ack routing and next-state selection
   always_comb begin
      w_busy   = (r_state != S_IDLE);
      w_expire = 1'b0;
      if (TIMEOUT_CYCLES > 0)
         w_expire = !reset && w_busy && !bus.mem_ack
                 && (r_wdog == 32'(TIMEOUT_CYCLES));
      w_end    = !reset && w_busy && (bus.mem_ack || w_expire);
      w_can    = !reset && ((r_state == S_IDLE) || w_end);

      w_err_i  = !reset && bus.cpui_request
              && (r_pi_valid || (r_state == S_BUSY_I && !w_end));
      w_err_d  = !reset && bus.cpud_request
              && (r_pd_valid || (r_state == S_BUSY_D && !w_end));
      w_live_i = !reset && bus.cpui_request && !w_err_i;
      w_live_d = !reset && bus.cpud_request && !w_err_d;
      w_cand_i = r_pi_valid || w_live_i;
      w_cand_d = r_pd_valid || w_live_d;

      // Data wins a tie only when fetch was granted last
      w_gnt_d  = w_can && w_cand_d && (!w_cand_i || !r_last_d);
      w_gnt_i  = w_can && w_cand_i && !w_gnt_d;

      w_d_write       = r_pd_valid ? r_pd_write : bus.cpud_write;
      bus.mem_request = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_addr    = 32'h0;
      bus.mem_wdata   = 32'h0;
      bus.mem_wmask   = 4'hF;
      if (w_gnt_i) begin
         bus.mem_request = 1'b1;
         bus.mem_addr    = r_pi_valid ? r_pi_addr : bus.cpui_addr;
      end else if (w_gnt_d) begin
         bus.mem_request = 1'b1;
         bus.mem_write   = w_d_write;
         bus.mem_addr    = r_pd_valid ? r_pd_addr : bus.cpud_addr;
         bus.mem_wdata   = r_pd_valid ? r_pd_wdata : bus.cpud_wdata;
         if (w_d_write)
            bus.mem_wmask = r_pd_valid ? r_pd_wmask : bus.cpud_wmask;
      end

      bus.cpui_ack   = w_end && (r_state == S_BUSY_I);
      bus.cpud_ack   = w_end && (r_state == S_BUSY_D);
      bus.cpui_rdata = bus.mem_ack ? bus.mem_rdata : 32'h0;
      bus.cpud_rdata = bus.mem_ack ? bus.mem_rdata : 32'h0;
      bus.bus_error  = w_err_i || w_err_d || w_expire;

      w_next = r_state;
      if (w_gnt_i)
         w_next = S_BUSY_I;
      else if (w_gnt_d)
         w_next = S_BUSY_D;
      else if (w_end)
         w_next = S_IDLE;
   end

   // State, pending slots, round-robin pointer and watchdog counter
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_last_d   <= 1'b0;
         r_wdog     <= 32'h0;
         r_pi_valid <= 1'b0;
         r_pi_addr  <= 32'h0;
         r_pd_valid <= 1'b0;
         r_pd_write <= 1'b0;
         r_pd_addr  <= 32'h0;
         r_pd_wdata <= 32'h0;
         r_pd_wmask <= 4'h0;
      end else begin
         r_state <= w_next;
         if (w_gnt_d)
            r_last_d <= 1'b1;
         else if (w_gnt_i)
            r_last_d <= 1'b0;

         if (bus.mem_request)
            r_wdog <= 32'h1;
         else if (w_busy && !w_end)
            r_wdog <= r_wdog + 32'h1;
         else
            r_wdog <= 32'h0;

         if (w_gnt_i) begin
            r_pi_valid <= 1'b0;
         end else if (w_live_i) begin
            r_pi_valid <= 1'b1;
            r_pi_addr  <= bus.cpui_addr;
         end

         if (w_gnt_d) begin
            r_pd_valid <= 1'b0;
         end else if (w_live_d) begin
            r_pd_valid <= 1'b1;
            r_pd_write <= bus.cpud_write;
            r_pd_addr  <= bus.cpud_addr;
            r_pd_wdata <= bus.cpud_wdata;
            r_pd_wmask <= bus.cpud_wmask;
         end
      end
   end
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard bench for cpu_bus_arbiter: expected memory requests and acks
// are queued as stimulus is driven and matched as the arbiter emits them.
module tb_cpu_bus_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   cpu_bus_arbiter_if bus ();

   cpu_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } mem_t;

   typedef struct {
      logic [31:0] data;
      logic        cmp;
   } ack_t;

   mem_t q_mem[$];
   ack_t q_i[$];
   ack_t q_d[$];
   mem_t mm;
   ack_t aa;

   int checks = 0;
   int failures = 0;
   int n_err = 0;
   int cyc = 0;
   int req_cyc = 0;
   int i_ack_cyc = 0;
   int e0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic exp_mem(logic [31:0] a, logic w,
                          logic [31:0] d, logic [3:0] m);
      mem_t t;
      t.addr = a; t.wr = w; t.wdata = d; t.wmask = m;
      q_mem.push_back(t);
   endtask

   task automatic exp_ack(logic dport, logic [31:0] d, logic c);
      ack_t t;
      t.data = d; t.cmp = c;
      if (dport) q_d.push_back(t);
      else q_i.push_back(t);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      bus.cpui_request = 1'b0;
      bus.cpud_request = 1'b0;
      bus.mem_ack = 1'b0;
   endtask

   task automatic req_i(logic [31:0] a);
      bus.cpui_request = 1'b1;
      bus.cpui_addr = a;
   endtask

   task automatic req_d(logic w, logic [31:0] a,
                        logic [31:0] d, logic [3:0] m);
      bus.cpud_request = 1'b1;
      bus.cpud_write = w;
      bus.cpud_addr = a;
      bus.cpud_wdata = d;
      bus.cpud_wmask = m;
   endtask

   task automatic ack(logic [31:0] d);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = d;
   endtask

   task automatic qempty(string tag);
      chk({tag, "_qmem"}, q_mem.size(), 0);
      chk({tag, "_qi"}, q_i.size(), 0);
      chk({tag, "_qd"}, q_d.size(), 0);
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: match every emitted request/ack against the scoreboard
   always @(negedge clock) begin
      if (bus.bus_error) n_err++;
      if (bus.mem_request) begin
         req_cyc = cyc;
         if (q_mem.size() == 0) begin
            chk("mem_req_unexpected", 1, 0);
         end else begin
            mm = q_mem.pop_front();
            chk("mem_addr", bus.mem_addr, mm.addr);
            chk("mem_write", 32'(bus.mem_write), 32'(mm.wr));
            chk("mem_wmask", 32'(bus.mem_wmask), 32'(mm.wmask));
            if (mm.wr) chk("mem_wdata", bus.mem_wdata, mm.wdata);
         end
      end
      if (bus.cpui_ack) begin
         i_ack_cyc = cyc;
         if (q_i.size() == 0) begin
            chk("cpui_ack_unexpected", 1, 0);
         end else begin
            aa = q_i.pop_front();
            if (aa.cmp) chk("cpui_rdata", bus.cpui_rdata, aa.data);
         end
      end
      if (bus.cpud_ack) begin
         if (q_d.size() == 0) begin
            chk("cpud_ack_unexpected", 1, 0);
         end else begin
            aa = q_d.pop_front();
            if (aa.cmp) chk("cpud_rdata", bus.cpud_rdata, aa.data);
         end
      end
   end

   initial begin
      bus.cpui_request = 1'b0;
      bus.cpui_addr = 32'h0;
      bus.cpud_request = 1'b0;
      bus.cpud_write = 1'b0;
      bus.cpud_addr = 32'h0;
      bus.cpud_wdata = 32'h0;
      bus.cpud_wmask = 4'h0;
      bus.mem_rdata = 32'h0;
      bus.mem_ack = 1'b0;

      // Reset state, including the cycle after release
      step();
      @(negedge clock);
      chk("rst_mem_req", 32'(bus.mem_request), 0);
      chk("rst_cpui_ack", 32'(bus.cpui_ack), 0);
      chk("rst_cpud_ack", 32'(bus.cpud_ack), 0);
      chk("rst_bus_err", 32'(bus.bus_error), 0);
      step();
      reset = 1'b0;
      @(negedge clock);
      chk("post_rst_mem_req", 32'(bus.mem_request), 0);
      chk("post_rst_err", 32'(bus.bus_error), 0);
      step();

      // Single fetch with 3-cycle memory latency
      exp_mem(32'hFFFF0000, 1'b0, 32'h0, 4'hF);
      req_i(32'hFFFF0000);
      step();
      step();
      step();
      exp_ack(1'b0, 32'h12345678, 1'b1);
      ack(32'h12345678);
      step();
      qempty("t1");

      // Simultaneous first requests: data wins, fetch follows at ack
      exp_mem(32'h200, 1'b1, 32'hAABBCCDD, 4'b0011);
      req_i(32'h100);
      req_d(1'b1, 32'h200, 32'hAABBCCDD, 4'b0011);
      step();
      exp_ack(1'b1, 32'h0, 1'b0);
      exp_mem(32'h100, 1'b0, 32'h0, 4'hF);
      ack(32'h0);
      step();
      exp_ack(1'b0, 32'hCAFE0001, 1'b1);
      ack(32'hCAFE0001);
      step();
      qempty("t2");

      // Queued data read during fetch, then a tie won by fetch
      exp_mem(32'h300, 1'b0, 32'h0, 4'hF);
      req_i(32'h300);
      step();
      req_d(1'b0, 32'h400, 32'h0, 4'h5);
      step();
      step();
      exp_ack(1'b0, 32'h11111111, 1'b1);
      exp_mem(32'h400, 1'b0, 32'h0, 4'hF);
      ack(32'h11111111);
      step();
      exp_ack(1'b1, 32'h22222222, 1'b1);
      ack(32'h22222222);
      step();
      exp_mem(32'h500, 1'b0, 32'h0, 4'hF);
      exp_mem(32'h600, 1'b0, 32'h0, 4'hF);
      req_i(32'h500);
      req_d(1'b0, 32'h600, 32'h0, 4'h0);
      step();
      exp_ack(1'b0, 32'h33333333, 1'b1);
      ack(32'h33333333);
      step();
      exp_ack(1'b1, 32'h44444444, 1'b1);
      ack(32'h44444444);
      step();
      qempty("t3");
      chk("t3_no_err", n_err, 0);

      // Double fetch request while outstanding
      e0 = n_err;
      exp_mem(32'h700, 1'b0, 32'h0, 4'hF);
      req_i(32'h700);
      step();
      req_i(32'h704);
      step();
      exp_ack(1'b0, 32'h55555555, 1'b1);
      ack(32'h55555555);
      step();
      step();
      qempty("t4");
      chk("t4_err_cnt", n_err - e0, 1);

      // Watchdog expiry with a silent memory, then a late ack
      e0 = n_err;
      exp_mem(32'h800, 1'b0, 32'h0, 4'hF);
      exp_ack(1'b0, 32'h0, 1'b1);
      bus.mem_rdata = 32'hDEADBEEF;
      req_i(32'h800);
      step();
      for (int k = 0; k < 8; k++) step();
      qempty("t5");
      chk("t5_wdog_latency", i_ack_cyc - req_cyc, 8);
      chk("t5_err_cnt", n_err - e0, 1);
      ack(32'h99999999);
      step();
      step();
      chk("t5_late_ack_err", n_err - e0, 1);

      // Reset while a data write is outstanding and fetch is pending
      e0 = n_err;
      exp_mem(32'h900, 1'b1, 32'h01020304, 4'hF);
      req_d(1'b1, 32'h900, 32'h01020304, 4'hF);
      step();
      req_i(32'hA00);
      step();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      ack(32'h77777777);
      step();
      exp_mem(32'hB00, 1'b0, 32'h0, 4'hF);
      req_i(32'hB00);
      @(negedge clock);
      chk("t6_grant_now", 32'(bus.mem_request), 1);
      step();
      exp_ack(1'b0, 32'h88888888, 1'b1);
      ack(32'h88888888);
      step();
      step();
      qempty("t6");
      chk("t6_err_cnt", n_err - e0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Shares the single memory port between the CPU instruction-fetch bus (cpui) and the load/store data bus (cpud). Both requesters issue one-cycle request pulses and wait for a one-cycle ack, and the arbiter turns these into one outstanding memory transaction at a time. It latches a request that arrives while the port is busy, picks between simultaneous requesters with round-robin priority, and routes the memory ack and read data back to the owner. An optional watchdog completes hung transactions.

## Interface
- TIMEOUT_CYCLES, 0: cycles without mem_ack before the watchdog fires; 0 disables the watchdog.
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- cpui_request  input  1  one-cycle instruction read request pulse
- cpui_addr  input  32  instruction address, valid with cpui_request
- cpui_rdata  output  32  instruction read data, valid with cpui_ack
- cpui_ack  output  1  one-cycle completion pulse to fetch
- cpud_request  input  1  one-cycle data request pulse
- cpud_write  input  1  1 = write, 0 = read; valid with cpud_request
- cpud_addr  input  32  data address
- cpud_wdata  input  32  write data
- cpud_wmask  input  4  byte enables, bit n covers wdata[8n+7:8n]
- cpud_rdata  output  32  data read data, valid with cpud_ack
- cpud_ack  output  1  one-cycle completion pulse to load/store unit
- mem_request  output  1  one-cycle request pulse to memory
- mem_write, mem_addr, mem_wdata, mem_wmask  output  1/32/32/4  transaction attributes, valid with mem_request
- mem_rdata  input  32  memory read data
- mem_ack  input  1  memory completion pulse
- bus_error  output  1  one-cycle pulse on protocol violation or watchdog expiry

## Operation
- **States**
  - IDLE: no transaction outstanding.
  - BUSY_I: an instruction transaction is outstanding.
  - BUSY_D: a data transaction is outstanding.
- **Pending slots:** one per port, holding the valid bit and the captured attributes. A request pulse fills its port's slot only if it cannot be granted in the same cycle.
- **Candidates:** each cycle, a port is a candidate if it has a live pulse this cycle or a valid pending slot. A pending slot takes precedence over a live pulse; when a slot exists, a live pulse on that port is an error.
- **Grant:** the arbiter grants when in IDLE, or in the cycle mem_ack (or watchdog expiry) ends the current transaction.
- **Round-robin:** with both ports candidates, grant the port not in last_grant. last_grant resets to I, so data wins the first tie.
- **On grant:**
  - mem_request=1; mem_* driven combinationally from the granted source.
  - Clear that port's slot; update last_grant.
  - Enter BUSY_I or BUSY_D.
  - A read grant drives mem_write=0 and mem_wmask=4'hF.
- **No grant:** mem_request=0 and mem_* are don't-care. With no candidates, the state returns to IDLE.
- **Ack routing:**
  - In BUSY_I, mem_ack drives cpui_ack=1 and cpui_rdata=mem_rdata combinationally. BUSY_D does the same for cpud.
  - The non-owner's ack is always 0.
  - rdata on a write ack is don't-care.
- **Protocol violations:** each pulses bus_error and is handled as follows.
  - A request pulse from a port that already has a pending slot or the outstanding transaction: the pulse is dropped.
- **Stray ack:** mem_ack while IDLE is dropped with no error. This covers acks from transactions cut off by reset.
- **Watchdog (TIMEOUT_CYCLES>0):**
  - Counter clears on each grant and increments every cycle in BUSY_*.
  - When the count reaches TIMEOUT_CYCLES with no mem_ack, the arbiter issues a synthetic ack to the owner with rdata=32'h0 and pulses bus_error, and the transaction counts as ended.
  - A late mem_ack then arrives in IDLE and is dropped. If a new grant was made in the expiry cycle, the late ack is indistinguishable from that grant's ack; an ack–request mix-up of this kind is accepted as fatal-error territory.
- **Simultaneous events:** mem_ack and a new pulse from the ending owner in the same cycle is legal. That pulse is a candidate for the same-cycle regrant, subject to round-robin.

## Timing
- Reset values: state=IDLE, both slots empty, last_grant=I, watchdog counter=0. All request, ack and error outputs are 0 in the reset cycle and in the cycle after.
- Reset mid-transaction drops the transaction and all pending slots; no ack is delivered to requesters.
- Grant latency from IDLE: 0 cycles; mem_request coincides with the requester pulse.
- Ack latency: 0 cycles; requester ack coincides with mem_ack.
- Back-to-back: after mem_ack, a pending request issues in the same cycle, so there are no dead cycles between transactions.
- At most one mem_request per mem_ack; never two outstanding.
- The watchdog fires in the cycle where TIMEOUT_CYCLES cycles have elapsed since mem_request.

## Test plan
- **Single fetch:** idle, cpui_request with addr 0xFFFF0000 → mem_request the same cycle with mem_addr=0xFFFF0000 and mem_write=0. Memory acks 3 cycles later with 0x12345678 → cpui_ack=1 and cpui_rdata=0x12345678 in that cycle; cpud_ack stays 0.
- **Simultaneous first requests:** cpui(0x100) and cpud write(0x200, wdata 0xAABBCCDD, mask 4'b0011) in the same cycle → data granted first with the mask passed through. At its ack, mem_request for 0x100 in the same cycle.
- **Queued request:** cpud read pulses while an instruction transaction is outstanding → no mem_request. On mem_ack, cpui_ack plus mem_request for the data address in the same cycle. At the next tie, the instruction port wins.
- **Double request:** second cpui pulse while its transaction is outstanding → bus_error pulse, only one mem_request, one cpui_ack.
- **Watchdog:** TIMEOUT_CYCLES=8, memory never acks → 8 cycles after mem_request, cpui_ack=1 with rdata=0 and bus_error=1. A later mem_ack in IDLE produces no ack and no error.
- **Reset mid-flight:** reset while BUSY_D with a pending cpui → after release, no acks and state IDLE. A stray mem_ack is ignored; a new cpui request is granted immediately.
